// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Iterates on operand magnitudes: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, followed by a sign-fix/writeback cycle.
// Optional feature macro MULDIV_FAST_MUL_EN: multiplies use a single
// WIDTH x WIDTH multiplier and finish in one cycle; divide is unchanged.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;       // mul: {partial, multiplier}; div: {rem, quo}
    logic [WIDTH-1:0]   opnd;      // |b|: multiplicand or divisor
    logic               is_div;
    logic               neg_res;   // operand signs differ
    logic               neg_rem;   // dividend was negative
    logic               div_zero;

    // Operand magnitudes; op[0] marks the signed variants.
    logic             a_neg, b_neg, accept;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign a_neg  = op[0] & a[WIDTH-1];
    assign b_neg  = op[0] & b[WIDTH-1];
    assign mag_a  = a_neg ? -a : a;
    assign mag_b  = b_neg ? -b : b;
    assign accept = (state_q == IDLE) && start && !abort;
    assign busy   = (state_q != IDLE);

    // Next-state logic; abort overrides every transition.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
                state_d = op[1] ? RUN : FIX;
`else
                state_d = RUN;
`endif
            end
            RUN:     if (cnt == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state always uses non-blocking assignments.
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // One iteration step for either algorithm.
    logic [WIDTH:0]     mul_sum, div_sh;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] step_acc;
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, opnd});
        div_diff = div_sh[WIDTH-1:0] - opnd;
        if (is_div)
            step_acc = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        else
            step_acc = {mul_sum, acc[WIDTH-1:1]};
    end

    // Sign correction applied in the FIX cycle.
    logic [2*WIDTH-1:0] res_mul;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
    always_comb begin
        res_mul = neg_res ? -acc : acc;
        quo     = acc[WIDTH-1:0];
        rem     = acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            res_hi = neg_rem ? -rem : rem;
            res_lo = div_zero ? '1 : (neg_res ? -quo : quo);
        end else begin
            res_hi = res_mul[2*WIDTH-1:WIDTH];
            res_lo = res_mul[WIDTH-1:0];
        end
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: datapath registers are reset too, so no X ever reaches HI/LO.
        if (!rst) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            cnt      <= CW'(WIDTH - 1);
            opnd     <= mag_b;
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= op[1] && (b == '0);
`ifdef MULDIV_FAST_MUL_EN
            if (op[1]) acc <= {{WIDTH{1'b0}}, mag_a};
            else       acc <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
            acc      <= {{WIDTH{1'b0}}, mag_a};
`endif
        end else if (state_q == RUN) begin
            acc <= step_acc;
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    // HI/LO: MTHI/MTLO any time; the FIX-cycle result is assigned last so it wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (mthi_we) hi <= wd;
            if (mtlo_we) lo <= wd;
            if (state_q == FIX && !abort) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

    // One-cycle completion pulse, coincident with the new HI/LO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) done <= 1'b0;
        else      done <= (state_q == FIX) && !abort;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors with literal expectations plus a
// transaction-level reference model compared against the DUT every cycle.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

    localparam int LAT_DIV = 33;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 33;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0, b = '0, wd = '0;
    logic        abort = 1'b0, mthi_we = 1'b0, mtlo_we = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .abort(abort), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wd(wd),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result from plain arithmetic: {HI, LO}.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint lx, ly;
        int     sx, sy;
        lx = longint'($signed(x));
        ly = longint'($signed(y));
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'd0: return {32'b0, x} * {32'b0, y};
            2'd1: return 64'(lx * ly);
            2'd2: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
        endcase
    endfunction

    function automatic int lat(input logic [1:0] o);
        return o[1] ? LAT_DIV : LAT_MUL;
    endfunction

    // Reference model: one pending operation with a countdown to its writeback.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    logic        m_busy, m_done;
    int          m_left;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hi <= '0; m_lo <= '0; m_res <= '0;
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (mthi_we) m_hi <= wd;
            if (mtlo_we) m_lo <= wd;
            if (abort) begin
                m_busy <= 1'b0;
            end else if (m_busy && m_left == 1) begin
                m_hi   <= m_res[63:32];
                m_lo   <= m_res[31:0];
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end else if (m_busy) begin
                m_left <= m_left - 1;
            end else if (start) begin
                m_res  <= ref_result(op, a, b);
                m_left <= lat(op);
                m_busy <= 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("model_hi", {32'b0, hi}, {32'b0, m_hi});
            check("model_lo", {32'b0, lo}, {32'b0, m_lo});
            check("model_busy", {63'b0, busy}, {63'b0, m_busy});
            check("model_done", {63'b0, done}, {63'b0, m_done});
        end
    end

    // Present an operation so that start is sampled at the next edge ("edge 0").
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #2;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #2;
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    // Count sampled cycles until done; k is the edge index relative to the caller's origin.
    task automatic wait_done(output int k);
        k = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            k++;
            if (k > 200) begin
                check("done_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] e_hi, input logic [31:0] e_lo);
        int k;
        issue(o, x, y);
        wait_done(k);
        check({name, "_lat"}, 64'(k), 64'(lat(o)));
        check({name, "_hi"}, {32'b0, hi}, {32'b0, e_hi});
        check({name, "_lo"}, {32'b0, lo}, {32'b0, e_lo});
        check({name, "_busy"}, {63'b0, busy}, 64'd0);
        @(negedge clk);
        check({name, "_pulse"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        int k;
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        @(posedge clk); #2 rst = 1'b1;

        run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  2'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("divu",      2'd2, 32'd100,       32'd7,         32'd2,         32'd14);
        run_op("div_neg",   2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf",   2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
        run_op("divu_z",    2'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_op("div_z",     2'd3, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op("mult_mix",  2'd1, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("div_rneg",  2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);

        // A new start in the done cycle is accepted.
        issue(2'd1, 32'd6, 32'd7);
        wait_done(k);
        start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd33;
        @(posedge clk); #2 start = 1'b0;
        wait_done(k);
        check("b2b_lat", 64'(k), 64'(LAT_DIV));
        check("b2b_lo", {32'b0, lo}, 64'd30);
        check("b2b_hi", {32'b0, hi}, 64'd10);

        // Preload HI/LO, then abort a DIVU at cycle 10.
        @(posedge clk); #2;
        mthi_we = 1'b1; mtlo_we = 1'b1; wd = 32'h11;
        @(posedge clk); #2;
        mthi_we = 1'b0; wd = 32'h22;
        @(posedge clk); #2;
        mtlo_we = 1'b0;
        check("mt_hi", {32'b0, hi}, 64'h11);
        check("mt_lo", {32'b0, lo}, 64'h22);
        issue(2'd2, 32'd9, 32'd2);
        repeat (9) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("abort_hi", {32'b0, hi}, 64'h11);
        check("abort_lo", {32'b0, lo}, 64'h22);

        // Start pulsed mid-run is ignored.
        issue(2'd2, 32'd1000, 32'd10);
        repeat (4) @(posedge clk);
        #2 start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
        @(posedge clk); #2 start = 1'b0;
        wait_done(k);
        check("ign_lat", 64'(k), 64'(LAT_DIV - 5));
        check("ign_lo", {32'b0, lo}, 64'd100);
        check("ign_hi", {32'b0, hi}, 64'd0);

        // Asynchronous reset at cycle 15 of a DIV.
        issue(2'd3, 32'hFFFF_FF00, 32'd3);
        repeat (14) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mrst_hi", {32'b0, hi}, 64'd0);
        check("mrst_lo", {32'b0, lo}, 64'd0);
        check("mrst_busy", {63'b0, busy}, 64'd0);
        check("mrst_done", {63'b0, done}, 64'd0);
        @(posedge clk); #2 rst = 1'b1;

        // MTLO after reset release.
        @(posedge clk); #2 mtlo_we = 1'b1; wd = 32'hABCD;
        @(posedge clk); #2 mtlo_we = 1'b0;
        check("mtlo", {32'b0, lo}, 64'hABCD);

        // MTHI during RUN is kept; MTHI coinciding with the result write loses.
        issue(2'd2, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #2 mthi_we = 1'b1; wd = 32'h77;
        @(posedge clk); #2 mthi_we = 1'b0;
        check("run_mthi", {32'b0, hi}, 64'h77);
        repeat (27) @(posedge clk);
        #2 mthi_we = 1'b1; wd = 32'h5555;
        @(posedge clk); #2 mthi_we = 1'b0;
        check("fix_done", {63'b0, done}, 64'd1);
        check("fix_hi", {32'b0, hi}, 64'd2);
        check("fix_lo", {32'b0, lo}, 64'd14);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
